// File: rtl/tt_um_serial_adder_param.sv
// Multi-cycle add/subtract unit, SLICE bits per cycle, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output.
module tt_um_serial_adder_param #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = $clog2(N + 1);

    generate
        if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
            $error("tt_um_serial_adder_param: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [SLICE:0]   slice_sum;
    logic             last;
    logic [WIDTH-1:0] sum_next;

    assign slice_sum = {1'b0, a_sh[SLICE-1:0]}
                     + {1'b0, b_sh[SLICE-1:0]}
                     + {{SLICE{1'b0}}, carry};

    assign last = (cnt == CW'(N - 1));

    // New slice enters at the MSB end; after N slices the word is aligned.
    assign sum_next = (sum >> SLICE)
                    | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));

`ifdef SERIAL_ADDER_OVF_EN
    logic msb_cin;
    assign msb_cin = slice_sum[SLICE-1] ^ a_sh[SLICE-1] ^ b_sh[SLICE-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_sh      <= a;
                        b_sh      <= sub ? ~b : b;
                        carry     <= sub;
                        cnt       <= '0;
                        sum       <= '0;
                        carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf       <= 1'b0;
`endif
                        in_ready  <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh  <= a_sh >> SLICE;
                    b_sh  <= b_sh >> SLICE;
                    carry <= slice_sum[SLICE];
                    sum   <= sum_next;
                    if (last) begin
                        carry_out <= slice_sum[SLICE];
`ifdef SERIAL_ADDER_OVF_EN
                        ovf       <= msb_cin ^ slice_sum[SLICE];
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_serial_adder_param.sv
// Bench for tt_um_serial_adder_param: SLICE=1, 4 and 8 instances against an arithmetic model.
// Signed-overflow checks are enabled when SERIAL_ADDER_OVF_EN is defined.
module tb_tt_um_serial_adder_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a   = 8'h00;
    logic [7:0] b   = 8'h00;
    logic       sub = 1'b0;

    logic       in_valid  [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic       carry_o   [3];
    logic [7:0] sum_o     [3];
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf_o     [3];
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tt_um_serial_adder_param #(.WIDTH(8), .SLICE(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum_o[0]), .carry_out(carry_o[0])
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_o[0])
`endif
    );

    tt_um_serial_adder_param #(.WIDTH(8), .SLICE(4)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum_o[1]), .carry_out(carry_o[1])
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_o[1])
`endif
    );

    tt_um_serial_adder_param #(.WIDTH(8), .SLICE(8)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum_o[2]), .carry_out(carry_o[2])
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf_o[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // {ovf, carry, sum} from plain integer arithmetic
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        int r;
        int sr;
        logic c;
        logic v;
        if (s) begin
            r  = int'(x) - int'(y);
            c  = (x >= y);
            sr = int'($signed(x)) - int'($signed(y));
        end else begin
            r  = int'(x) + int'(y);
            c  = (r > 255);
            sr = int'($signed(x)) + int'($signed(y));
        end
        v = (sr > 127) || (sr < -128);
        return {v, c, r[7:0]};
    endfunction

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (!in_ready[k] && n < 20) begin
            step();
            n++;
        end
        check("in_ready_wait", 32'(in_ready[k]), 32'd1);
    endtask

    task automatic check_result(input int k, input logic [9:0] e, input string tag);
        check({tag, "_sum"}, 32'(sum_o[k]), 32'(e[7:0]));
        check({tag, "_carry"}, 32'(carry_o[k]), 32'(e[8]));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf_o[k]), 32'(e[9]));
`endif
    endtask

    task automatic run_op(input int k, input int lat, input logic [7:0] oa,
                          input logic [7:0] ob, input logic os, input string tag);
        int n;
        logic [9:0] e;
        e = model(oa, ob, os);
        wait_ready(k);
        a = oa;
        b = ob;
        sub = os;
        in_valid[k] = 1'b1;
        step();
        in_valid[k] = 1'b0;
        n = 0;
        while (!out_valid[k] && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
        check({tag, "_out_valid"}, 32'(out_valid[k]), 32'd1);
        check_result(k, e, tag);
        step();
        check({tag, "_release"}, 32'(out_valid[k]), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready[k]), 32'd1);
    endtask

    task automatic stream(input int k, input int lat, input int count);
        int n;
        int tp;
        logic [7:0] oa;
        logic [7:0] ob;
        logic os;
        logic [9:0] e;
        tp = 0;
        wait_ready(k);
        for (int i = 0; i < count; i++) begin
            oa = 8'($urandom);
            ob = 8'($urandom);
            os = 1'($urandom);
            e  = model(oa, ob, os);
            a = oa;
            b = ob;
            sub = os;
            check("stream_ready", 32'(in_ready[k]), 32'd1);
            in_valid[k] = 1'b1;
            step();
            if (i > 0) check("stream_period", 32'(cyc - tp), 32'(lat + 2));
            tp = cyc;
            n = 0;
            while (!out_valid[k] && n < 40) begin
                step();
                n++;
            end
            check("stream_latency", 32'(n), 32'(lat));
            check_result(k, e, "stream");
            step();
        end
        in_valid[k] = 1'b0;
    endtask

    initial begin
        logic [9:0] e;
        int n;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end

        step(2);
        for (int k = 0; k < 3; k++) begin
            check("rst_in_ready", 32'(in_ready[k]), 32'd0);
            check("rst_out_valid", 32'(out_valid[k]), 32'd0);
            check("rst_sum", 32'(sum_o[k]), 32'd0);
            check("rst_carry", 32'(carry_o[k]), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
            check("rst_ovf", 32'(ovf_o[k]), 32'd0);
`endif
        end
        rst = 1'b0;
        step();
        check("ready_after_rst", 32'(in_ready[0]), 32'd1);

        run_op(0, 8, 8'h7F, 8'h01, 1'b0, "t1_7f_01");
        run_op(0, 8, 8'hFF, 8'h01, 1'b0, "t2_ff_01");
        run_op(0, 8, 8'h05, 8'h07, 1'b1, "t2_05_m_07");
        check("t2_direct_sum", 32'(sum_o[0]), 32'h0FE);

        // Backpressure with operands disturbed during BUSY and DONE
        e = model(8'h3C, 8'h55, 1'b0);
        out_ready[0] = 1'b0;
        wait_ready(0);
        a = 8'h3C;
        b = 8'h55;
        sub = 1'b0;
        in_valid[0] = 1'b1;
        step();
        a = 8'hFF;
        b = 8'hAA;
        sub = 1'b1;
        n = 0;
        while (!out_valid[0] && n < 40) begin
            check("bp_busy_in_ready", 32'(in_ready[0]), 32'd0);
            step();
            n++;
        end
        check("bp_latency", 32'(n), 32'd8);
        check_result(0, e, "bp");
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", 32'(out_valid[0]), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready[0]), 32'd0);
            check_result(0, e, "bp_hold");
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        step();
        check("bp_release", 32'(out_valid[0]), 32'd0);
        check("bp_ready_back", 32'(in_ready[0]), 32'd1);

        // Reset in the middle of an operation
        wait_ready(0);
        a = 8'hFF;
        b = 8'hFF;
        sub = 1'b0;
        in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        step(2);
        rst = 1'b1;
        step();
        check("abort_out_valid", 32'(out_valid[0]), 32'd0);
        check("abort_sum", 32'(sum_o[0]), 32'd0);
        check("abort_carry", 32'(carry_o[0]), 32'd0);
        check("abort_in_ready", 32'(in_ready[0]), 32'd0);
        rst = 1'b0;
        step();
        check("abort_ready_back", 32'(in_ready[0]), 32'd1);
        run_op(0, 8, 8'h10, 8'h20, 1'b0, "t4_10_20");

        run_op(1, 2, 8'h9C, 8'h68, 1'b0, "t5_s4");
        run_op(2, 1, 8'h9C, 8'h68, 1'b0, "t5_s8");
        run_op(1, 2, 8'h80, 8'h01, 1'b1, "t5_s4_sub");
        run_op(2, 1, 8'h00, 8'h00, 1'b1, "t5_s8_zero");

        stream(0, 8, 1000);
        stream(1, 2, 200);
        stream(2, 1, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
